// File: rtl/knn_vector_streamer_pkg.sv
// Shared definitions for the KNN vector streamer: state encoding and the
// helper that sizes the per-vector element counter.
package knn_vector_streamer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_Q = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOAD_Q = ST_LOAD_Q,
    STREAM = ST_STREAM,
    FINISH = ST_FINISH
  } state_t;

  // Width of a counter that indexes n elements (at least one bit).
  function automatic int dim_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/knn_query_buffer.sv
// Query vector storage: one synchronous write port, one asynchronous read
// port, deliberately not reset.
module knn_query_buffer
  import knn_vector_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = dim_bits(DEPTH)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/knn_vector_streamer.sv
// Buffers one query vector, then pairs each streamed training element with
// the matching query element for the distance calculator.
module knn_vector_streamer
  import knn_vector_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIMENSIONS = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         num_vectors,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic signed [DATA_WIDTH-1:0] data1,
  output logic signed [DATA_WIDTH-1:0] data2,
  output logic                         dataIn_Valid,
  output logic                         last_elem,
  output logic [CNT_WIDTH-1:0]         vec_index,
  output logic                         busy,
  output logic                         done
);

  localparam int DIM_W = dim_bits(DIMENSIONS);
  localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(DIMENSIONS - 1);

  state_t                       state, state_next;
  logic [DIM_W-1:0]             dim_cnt;
  logic [CNT_WIDTH-1:0]         vec_cnt;
  logic [CNT_WIDTH-1:0]         num_lat;
  logic                         accept;
  logic                         dim_wrap;
  logic                         last_vec;
  logic                         stream_accept;
  logic signed [DATA_WIDTH-1:0] q_rd;

  assign s_ready       = (state == LOAD_Q) || (state == STREAM);
  assign accept        = s_valid && s_ready;
  assign dim_wrap      = (dim_cnt == DIM_LAST);
  assign last_vec      = (vec_cnt == num_lat - 1'b1);
  assign stream_accept = accept && (state == STREAM);

  knn_query_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DIMENSIONS),
    .ADDR_W     (DIM_W)
  ) u_query (
    .clk     (clk),
    .wr_en   (accept && (state == LOAD_Q)),
    .wr_addr (dim_cnt),
    .wr_data (s_data),
    .rd_addr (dim_cnt),
    .rd_data (q_rd)
  );

  // FINISH lingers while the final pair is still on the outputs, so done
  // lands one cycle after it (or straight after start for an empty job).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (num_vectors != '0) ? LOAD_Q : FINISH;
      LOAD_Q:  if (accept && dim_wrap) state_next = STREAM;
      STREAM:  if (accept && dim_wrap && last_vec) state_next = FINISH;
      FINISH:  if (!dataIn_Valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dim_cnt      <= '0;
      vec_cnt      <= '0;
      num_lat      <= '0;
      data1        <= '0;
      data2        <= '0;
      dataIn_Valid <= 1'b0;
      last_elem    <= 1'b0;
      vec_index    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      dataIn_Valid <= stream_accept;
      busy         <= (state_next != IDLE);
      done         <= (state_next == FINISH) && !stream_accept;
      if ((state == IDLE) && start) begin
        dim_cnt <= '0;
        vec_cnt <= '0;
        if (num_vectors != '0) num_lat <= num_vectors;
      end
      if (accept) begin
        dim_cnt <= dim_wrap ? '0 : dim_cnt + 1'b1;
      end
      if (stream_accept) begin
        data1     <= q_rd;
        data2     <= s_data;
        vec_index <= vec_cnt;
        last_elem <= dim_wrap;
        if (dim_wrap) vec_cnt <= last_vec ? '0 : vec_cnt + 1'b1;
      end
    end
  end

endmodule
